// File: rtl/uop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : Utilities (package)
// Description : Shared micro-op types for the issue path. Holds the ALU
//               micro-op record (alu_inp_t), its sub-opcode enumeration,
//               default sizing constants for uop_sequencer, and the
//               classification helpers used for issue-group truncation.
// Revision    : 1.0 - initial release
// ============================================================================
package Utilities;

    // Default sizing for uop_sequencer and uop_ring
    localparam int c_max_uops_default    = 6;
    localparam int c_issue_width_default = 2;
    localparam int c_depth_default       = 16;

    // Architectural operand selectors used by the cracker
    localparam logic [3:0] c_reg_rax  = 4'd0;
    localparam logic [3:0] c_reg_rsp  = 4'd4;
    localparam logic [3:0] c_reg_rip  = 4'd14;
    localparam logic [3:0] c_reg_rimm = 4'd15;

    // NOP is encoded as zero so an all-zero record is a harmless bubble.
    typedef enum logic [4:0] {
        NOP   = 5'd0,
        ADD   = 5'd1,
        SUB   = 5'd2,
        MOVE  = 5'd3,
        LOAD  = 5'd4,
        STORE = 5'd5,
        IMUL  = 5'd6,
        JMP   = 5'd7,
        JB    = 5'd8,
        JNB   = 5'd9,
        JZ    = 5'd10,
        JNZ   = 5'd11,
        JL    = 5'd12,
        JNL   = 5'd13,
        JLE   = 5'd14,
        JNLE  = 5'd15,
        MNOP  = 5'd16
    } sub_opcode_t;

    typedef struct packed {
        sub_opcode_t op;
        logic [3:0]  dst;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic [15:0] imm;
    } alu_inp_t;

    // A branch must close its issue group: nothing younger may issue with it.
    function automatic logic is_branch_uop(input alu_inp_t u);
        case (u.op)
            JMP, JB, JNB, JZ, JNZ, JL, JNL, JLE, JNLE: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // A serialising micro-op must issue alone in lane 0.
    function automatic logic is_serial_uop(input alu_inp_t u);
        return (u.op == MNOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uop_sequencer_ring.sv
`default_nettype none
// ============================================================================
// Module      : uop_ring
// Description : Circular micro-op storage. MAX_UOPS write ports land at
//               tail+k, ISSUE_WIDTH combinational read ports present
//               head+i. Pointer management lives in the parent.
// Ports       : clk      - clock
//               wr_en    - per-slot write enable (slot k -> tail+k)
//               wr_data  - per-slot write data
//               tail     - write base index
//               head     - read base index
//               rd_data  - per-lane read data (lane i <- head+i)
// Revision    : 1.0 - initial release
// ============================================================================
module uop_ring
    import Utilities::*;
#(
    parameter int DEPTH       = c_depth_default,
    parameter int MAX_UOPS    = c_max_uops_default,
    parameter int ISSUE_WIDTH = c_issue_width_default
) (
    input  logic                             clk,
    input  logic [MAX_UOPS-1:0]              wr_en,
    input  alu_inp_t [MAX_UOPS-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0]         tail,
    input  logic [$clog2(DEPTH)-1:0]         head,
    output alu_inp_t [ISSUE_WIDTH-1:0]       rd_data
);

    localparam int ADDR_W = $clog2(DEPTH);

    // Contents need no reset: lanes are qualified by occupancy upstream.
    alu_inp_t r_mem [DEPTH];

    // DEPTH is a power of two, so index arithmetic wraps for free.
    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_UOPS; k++) begin
            if (wr_en[k]) begin
                r_mem[tail + ADDR_W'(k)] <= wr_data[k];
            end
        end
    end

    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_rd
        assign rd_data[i] = r_mem[head + ADDR_W'(i)];
    end

endmodule
`default_nettype wire

// File: rtl/uop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uop_sequencer
// Description : Buffers cracked micro-op bundles and presents them on
//               ISSUE_WIDTH issue lanes in program order, truncating issue
//               groups at branches and around serialising micro-ops.
// Ports       : clk, reset   - clock, asynchronous active-high reset
//               in_valid/in_ready/in_uops/in_cnt - bundle enqueue
//               out_uops/out_valid/out_take      - issue lanes and consume
//               flush        - discard everything buffered
//               occupancy    - buffered entry count
//               err          - sticky protocol-error flag
// Revision    : 1.0 - initial release
// ============================================================================
module uop_sequencer
    import Utilities::*;
#(
    parameter int MAX_UOPS    = c_max_uops_default,
    parameter int ISSUE_WIDTH = c_issue_width_default,
    parameter int DEPTH       = c_depth_default
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  alu_inp_t [MAX_UOPS-1:0]            in_uops,
    input  logic [$clog2(MAX_UOPS+1)-1:0]      in_cnt,
    output alu_inp_t [ISSUE_WIDTH-1:0]         out_uops,
    output logic [ISSUE_WIDTH-1:0]             out_valid,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   out_take,
    input  logic                               flush,
    output logic [$clog2(DEPTH+1)-1:0]         occupancy,
    output logic                               err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(MAX_UOPS+1);
    localparam int TAKE_W = $clog2(ISSUE_WIDTH+1);
    localparam int OCC_W  = $clog2(DEPTH+1);

    // Configuration guards: a full bundle plus a full issue group must fit.
    if (DEPTH < MAX_UOPS + ISSUE_WIDTH) begin : g_depth_too_small
        $error("uop_sequencer: DEPTH must be >= MAX_UOPS + ISSUE_WIDTH");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_not_pow2
        $error("uop_sequencer: DEPTH must be a power of two");
    end

    logic [ADDR_W-1:0]              r_head;
    logic [ADDR_W-1:0]              r_tail;
    logic [OCC_W-1:0]               r_occ;
    logic                           r_err;

    logic                           w_room;
    logic                           w_accept;
    logic                           w_cnt_ok;
    logic                           w_enq;
    logic [CNT_W-1:0]               w_enq_cnt;
    logic [MAX_UOPS-1:0]            w_wr_en;
    alu_inp_t [ISSUE_WIDTH-1:0]     w_rd;
    logic [TAKE_W-1:0]              w_nvalid;
    logic [TAKE_W-1:0]              w_take;
    logic                           w_take_err;

    // ---------------------------------------------------------------- enqueue
    // Readiness is judged against a worst-case bundle so it never depends on
    // in_cnt, keeping in_ready off the cracker's combinational path.
    assign w_room    = (DEPTH - int'(r_occ)) >= MAX_UOPS;
    assign in_ready  = !reset && !flush && w_room;
    assign w_accept  = in_valid && in_ready;
    assign w_cnt_ok  = int'(in_cnt) <= MAX_UOPS;
    assign w_enq     = w_accept && w_cnt_ok;
    assign w_enq_cnt = w_enq ? in_cnt : '0;

    always_comb begin
        w_wr_en = '0;
        for (int k = 0; k < MAX_UOPS; k++) begin
            w_wr_en[k] = w_enq && (k < int'(in_cnt));
        end
    end

    uop_ring #(
        .DEPTH       (DEPTH),
        .MAX_UOPS    (MAX_UOPS),
        .ISSUE_WIDTH (ISSUE_WIDTH)
    ) u_ring (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_data (in_uops),
        .tail    (r_tail),
        .head    (r_head),
        .rd_data (w_rd)
    );

    // ------------------------------------------------------------ issue lanes
    // Walk lanes oldest-first. A branch closes the group after itself; a
    // serialising op closes the group before itself unless it is in lane 0,
    // where it issues and also closes the group.
    always_comb begin : p_lanes
        logic stop;
        logic lane_ok;
        stop      = 1'b0;
        lane_ok   = 1'b0;
        w_nvalid  = '0;
        out_valid = '0;
        out_uops  = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            lane_ok = (int'(r_occ) > i) && !stop;
            if (lane_ok && is_serial_uop(w_rd[i]) && (i != 0)) begin
                lane_ok = 1'b0;
                stop    = 1'b1;
            end
            if (lane_ok && (is_branch_uop(w_rd[i]) || is_serial_uop(w_rd[i]))) begin
                stop = 1'b1;
            end
            out_valid[i] = lane_ok;
            out_uops[i]  = lane_ok ? w_rd[i] : '0;
            if (lane_ok) begin
                w_nvalid = w_nvalid + TAKE_W'(1);
            end
        end
    end

    // Over-consumption is clamped so the pointers never run past valid data.
    assign w_take_err = out_take > w_nvalid;
    assign w_take     = w_take_err ? w_nvalid : out_take;

    // ----------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_err  <= 1'b0;
        end else if (flush) begin
            // Flush wins over any same-cycle enqueue or take.
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= r_head + ADDR_W'(w_take);
            r_tail <= r_tail + ADDR_W'(w_enq_cnt);
            r_occ  <= r_occ + OCC_W'(w_enq_cnt) - OCC_W'(w_take);
            if (w_take_err || (w_accept && !w_cnt_ok)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign occupancy = r_occ;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uop_sequencer
// Description : Directed self-checking bench for uop_sequencer with a small
//               in-order reference queue for the wrap-around stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uop_sequencer;
    import Utilities::*;

    localparam int MAX_UOPS    = 6;
    localparam int ISSUE_WIDTH = 2;
    localparam int DEPTH       = 16;

    logic                        clk      = 1'b0;
    logic                        reset    = 1'b1;
    logic                        in_valid = 1'b0;
    logic                        flush    = 1'b0;
    alu_inp_t [MAX_UOPS-1:0]     in_uops  = '0;
    logic [2:0]                  in_cnt   = '0;
    logic [1:0]                  out_take = '0;
    logic                        in_ready;
    alu_inp_t [ISSUE_WIDTH-1:0]  out_uops;
    logic [ISSUE_WIDTH-1:0]      out_valid;
    logic [4:0]                  occupancy;
    logic                        err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uop_sequencer #(
        .MAX_UOPS    (MAX_UOPS),
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_uops   (in_uops),
        .in_cnt    (in_cnt),
        .out_uops  (out_uops),
        .out_valid (out_valid),
        .out_take  (out_take),
        .flush     (flush),
        .occupancy (occupancy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic alu_inp_t mk(input sub_opcode_t op, input logic [3:0] dst,
                                    input logic [3:0] sa, input logic [3:0] sb,
                                    input logic [15:0] imm);
        alu_inp_t u;
        u.op    = op;
        u.dst   = dst;
        u.src_a = sa;
        u.src_b = sb;
        u.imm   = imm;
        return u;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_cnt   = '0;
        in_uops  = '0;
        out_take = '0;
        flush    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        alu_inp_t ua, ub, uc;
        alu_inp_t q[$];
        int sent, cyc, tag, n, exp_nv;
        logic exp_rdy;

        // ------------------------------------------------------------ reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_uops", 64'(out_uops), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ------------------------------------------- push: SUB RSP, STORE
        ua = mk(SUB, c_reg_rsp, c_reg_rsp, c_reg_rimm, 16'd8);
        ub = mk(STORE, c_reg_rax, c_reg_rsp, c_reg_rax, 16'd0);
        in_uops[0] = ua; in_uops[1] = ub; in_cnt = 3'd2; in_valid = 1'b1;
        #1;
        check("push_not_yet_visible", 64'(out_valid), 64'd0);
        tick();
        idle();
        #1;
        check("push_valid", 64'(out_valid), 64'b11);
        check("push_lane0", 64'(out_uops[0]), 64'(ua));
        check("push_lane1", 64'(out_uops[1]), 64'(ub));
        check("push_occ", 64'(occupancy), 64'd2);
        out_take = 2'd2;
        tick();
        idle();
        #1;
        check("push_drain_occ", 64'(occupancy), 64'd0);
        check("push_drain_valid", 64'(out_valid), 64'd0);
        check("push_drain_uops", 64'(out_uops), 64'd0);
        check("push_err", 64'(err), 64'd0);

        // ------------------------------------------------ empty bundle
        in_valid = 1'b1; in_cnt = 3'd0;
        tick();
        idle();
        #1;
        check("cnt0_occ", 64'(occupancy), 64'd0);
        check("cnt0_err", 64'(err), 64'd0);

        // ------------------------------- two 6-uop bundles: backpressure
        for (int k = 0; k < 6; k++)
            in_uops[k] = mk(sub_opcode_t'(5'(k + 1)), 4'(k), 4'd1, 4'd2, 16'(16'h100 + k));
        ua = in_uops[0];
        uc = in_uops[2];
        in_cnt = 3'd6; in_valid = 1'b1;
        tick();
        for (int k = 0; k < 6; k++)
            in_uops[k] = mk(LOAD, 4'(k), c_reg_rsp, 4'd0, 16'(16'h200 + k));
        #1;
        check("bk_ready_at6", 64'(in_ready), 64'd1);
        tick();
        in_cnt = 3'd2;
        #1;
        check("bk_occ12", 64'(occupancy), 64'd12);
        check("bk_ready_low", 64'(in_ready), 64'd0);
        check("bk_lane0", 64'(out_uops[0]), 64'(ua));
        tick();
        idle();
        #1;
        check("bk_rejected_occ", 64'(occupancy), 64'd12);
        out_take = 2'd2;
        tick();
        idle();
        #1;
        check("bk_occ10", 64'(occupancy), 64'd10);
        check("bk_ready_high", 64'(in_ready), 64'd1);
        check("bk_lane0_after_take", 64'(out_uops[0]), 64'(uc));
        out_take = 2'd2;
        repeat (5) tick();
        idle();
        #1;
        check("bk_drained", 64'(occupancy), 64'd0);
        check("bk_err", 64'(err), 64'd0);

        // ------------------------------------- branch: ADD, JZ, MOVE
        ua = mk(ADD, c_reg_rax, c_reg_rip, c_reg_rimm, 16'h0040);
        ub = mk(JZ, c_reg_rip, c_reg_rip, c_reg_rimm, 16'h0010);
        uc = mk(MOVE, 4'd1, 4'd2, 4'd0, 16'h0000);
        in_uops[0] = ua; in_uops[1] = ub; in_uops[2] = uc; in_cnt = 3'd3; in_valid = 1'b1;
        tick();
        idle();
        #1;
        check("br_valid", 64'(out_valid), 64'b11);
        check("br_lane0", 64'(out_uops[0]), 64'(ua));
        check("br_lane1_jz", 64'(out_uops[1]), 64'(ub));
        out_take = 2'd2;
        tick();
        idle();
        #1;
        check("br_move_alone", 64'(out_valid), 64'b01);
        check("br_move_lane0", 64'(out_uops[0]), 64'(uc));
        out_take = 2'd1;
        tick();
        idle();

        // Branch in lane 0 hides the younger MOVE.
        ua = mk(JMP, c_reg_rip, c_reg_rip, c_reg_rimm, 16'h0080);
        in_uops[0] = ua; in_uops[1] = uc; in_cnt = 3'd2; in_valid = 1'b1;
        tick();
        idle();
        #1;
        check("jmp_trunc_valid", 64'(out_valid), 64'b01);
        check("jmp_trunc_lane1_zero", 64'(out_uops[1]), 64'd0);
        out_take = 2'd1;
        tick();
        idle();
        #1;
        check("jmp_then_move", 64'(out_uops[0]), 64'(uc));
        out_take = 2'd1;
        tick();
        idle();

        // ----------------------------- serialising: ADD then (MNOP, MOVE)
        ua = mk(ADD, 4'd3, 4'd3, c_reg_rimm, 16'h0001);
        ub = mk(MNOP, 4'd0, 4'd0, 4'd0, 16'h0005);
        in_uops[0] = ua; in_cnt = 3'd1; in_valid = 1'b1;
        tick();
        in_uops[0] = ub; in_uops[1] = uc; in_cnt = 3'd2; in_valid = 1'b1;
        tick();
        idle();
        #1;
        check("ser_occ", 64'(occupancy), 64'd3);
        check("ser_add_alone", 64'(out_valid), 64'b01);
        check("ser_add_lane0", 64'(out_uops[0]), 64'(ua));
        check("ser_lane1_zero", 64'(out_uops[1]), 64'd0);
        out_take = 2'd1;
        tick();
        idle();
        #1;
        check("ser_mnop_alone", 64'(out_valid), 64'b01);
        check("ser_mnop_lane0", 64'(out_uops[0]), 64'(ub));
        out_take = 2'd1;
        tick();
        idle();
        #1;
        check("ser_move_lane0", 64'(out_uops[0]), 64'(uc));
        check("ser_move_valid", 64'(out_valid), 64'b01);
        out_take = 2'd1;
        tick();
        idle();
        #1;
        check("ser_empty", 64'(occupancy), 64'd0);

        // ----------------------------------------- fill to 14 then flush
        for (int k = 0; k < 6; k++)
            in_uops[k] = mk(ADD, 4'd1, 4'd1, 4'd2, 16'(16'h300 + k));
        in_valid = 1'b1; in_cnt = 3'd6;
        tick();
        in_cnt = 3'd4;
        tick();
        in_cnt = 3'd4;
        tick();
        flush = 1'b1; in_valid = 1'b1; in_cnt = 3'd2; out_take = 2'd2;
        #1;
        check("fl_occ14", 64'(occupancy), 64'd14);
        check("fl_ready_low", 64'(in_ready), 64'd0);
        tick();
        idle();
        #1;
        check("fl_occ0", 64'(occupancy), 64'd0);
        check("fl_no_valid", 64'(out_valid), 64'd0);
        check("fl_err", 64'(err), 64'd0);
        ua = mk(STORE, 4'd2, 4'd3, 4'd4, 16'h0abc);
        in_uops[0] = ua; in_cnt = 3'd1; in_valid = 1'b1;
        tick();
        idle();
        #1;
        check("fl_restart_lane0", 64'(out_uops[0]), 64'(ua));
        check("fl_restart_valid", 64'(out_valid), 64'b01);
        out_take = 2'd1;
        tick();
        idle();

        // ------------------------------ random stream across pointer wrap
        sent = 0; cyc = 0; tag = 0; n = 0;
        while ((sent < 40 || q.size() != 0) && cyc < 2000) begin
            exp_nv  = (q.size() > 2) ? 2 : q.size();
            exp_rdy = (DEPTH - q.size()) >= MAX_UOPS;
            in_valid = 1'b0; in_cnt = '0; in_uops = '0;
            if (sent < 40) begin
                n = $urandom_range(0, 6);
                in_valid = 1'b1;
                in_cnt   = 3'(n);
                for (int k = 0; k < n; k++)
                    in_uops[k] = mk(sub_opcode_t'(5'($urandom_range(1, 6))),
                                    4'($urandom_range(0, 15)), 4'd0, 4'd0, 16'(tag + k));
            end
            out_take = 2'(exp_nv);
            #1;
            check("rnd_occ", 64'(occupancy), 64'(q.size()));
            check("rnd_ready", 64'(in_ready), 64'(exp_rdy));
            check("rnd_valid", 64'(out_valid), 64'((1 << exp_nv) - 1));
            for (int i = 0; i < exp_nv; i++)
                check("rnd_lane", 64'(out_uops[i]), 64'(q[i]));
            tick();
            for (int i = 0; i < exp_nv; i++)
                void'(q.pop_front());
            if (in_valid && exp_rdy) begin
                for (int k = 0; k < n; k++)
                    q.push_back(in_uops[k]);
                sent++;
                tag += n;
            end
            cyc++;
        end
        idle();
        check("rnd_within_budget", 64'(cyc < 2000), 64'd1);
        check("rnd_err", 64'(err), 64'd0);

        // ------------------------------------- over-take sets sticky err
        #1;
        in_uops[0] = ua; in_cnt = 3'd1; in_valid = 1'b1;
        tick();
        idle();
        #1;
        check("ot_one_valid", 64'(out_valid), 64'b01);
        check("ot_err_before", 64'(err), 64'd0);
        out_take = 2'd2;
        tick();
        idle();
        #1;
        check("ot_err_set", 64'(err), 64'd1);
        check("ot_clamped_occ", 64'(occupancy), 64'd0);
        tick();
        #1;
        check("ot_err_sticky", 64'(err), 64'd1);
        reset = 1'b1;
        #1;
        check("ot_err_cleared", 64'(err), 64'd0);
        tick();
        reset = 1'b0;

        // --------------------------------------- oversized in_cnt dropped
        for (int k = 0; k < 6; k++)
            in_uops[k] = mk(ADD, 4'd1, 4'd1, 4'd1, 16'(k));
        in_cnt = 3'd7; in_valid = 1'b1;
        tick();
        idle();
        #1;
        check("big_cnt_err", 64'(err), 64'd1);
        check("big_cnt_dropped", 64'(occupancy), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // ------------------------------------------ reset mid-operation
        for (int k = 0; k < 3; k++)
            in_uops[k] = mk(MOVE, 4'(k), 4'd0, 4'd0, 16'(k));
        in_cnt = 3'd3; in_valid = 1'b1;
        tick();
        idle();
        #1;
        check("mid_occ3", 64'(occupancy), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_occ", 64'(occupancy), 64'd0);
        check("mid_async_valid", 64'(out_valid), 64'd0);
        check("mid_async_uops", 64'(out_uops), 64'd0);
        check("mid_async_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_after_ready", 64'(in_ready), 64'd1);
        check("mid_after_occ", 64'(occupancy), 64'd0);
        check("mid_after_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
